// File: rtl/apb_regfile_slave_pkg.sv
// rtl/apb_regfile_slave_pkg.sv - shared types, constants and byte-merge helper for the APB register file
package apb_pkg;

   // Transfer phases tracked by the slave
   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } apb_state_e;

   // Bit of prot that marks a privileged access
   localparam int PROT_PRIV_BIT = 0;

   // Widest word the merge helper handles; callers widen/truncate around it
   localparam int MERGE_WIDTH = 1024;
   localparam int MERGE_STRB  = MERGE_WIDTH / 8;

   // Replace the bytes of old selected by strb with the matching bytes of wdata
   function automatic logic [MERGE_WIDTH-1:0] byte_merge(
      input logic [MERGE_WIDTH-1:0] old,
      input logic [MERGE_WIDTH-1:0] wdata,
      input logic [MERGE_STRB-1:0]  strb
   );
      logic [MERGE_WIDTH-1:0] res;
      res = old;
      for (int b = 0; b < MERGE_STRB; b++) begin
         if (strb[b]) begin
            res[8*b +: 8] = wdata[8*b +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/apb_regfile_slave_if.sv
// rtl/apb_regfile_slave_if.sv - APB bus bundle between a master and the register file slave
interface apb_regfile_slave_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   localparam int DATA_STRB = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0] paddr;
   logic [2:0]            prot;
   logic                  pwrite;
   logic                  psel;
   logic                  penable;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [DATA_STRB-1:0]  pstrb;
   logic                  pready;
   logic                  slverr;
   logic [DATA_WIDTH-1:0] prdata;

   modport master (
      output paddr, prot, pwrite, psel, penable, pwdata, pstrb,
      input  pready, slverr, prdata
   );

   modport slave (
      input  paddr, prot, pwrite, psel, penable, pwdata, pstrb,
      output pready, slverr, prdata
   );
endinterface

// File: rtl/apb_regfile_slave_addr_decode.sv
// rtl/apb_regfile_slave_addr_decode.sv - maps a byte address to a register index and flags illegal accesses
module apb_addr_decode
   import apb_pkg::*;
#(
   parameter int                  ADDR_WIDTH = 32,
   parameter int                  DATA_STRB  = 4,
   parameter int                  NUM_REGS   = 16,
   parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
   parameter bit                  PRIV_ONLY  = 1'b0
) (
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic                  pwrite,
   input  logic [2:0]            prot,
   output logic [7:0]            idx,
   output logic                  hit,
   output logic                  err
);
   localparam int                    LSB        = $clog2(DATA_STRB);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(DATA_STRB - 1);
   localparam logic [ADDR_WIDTH-1:0] LIMIT      = ADDR_WIDTH'(NUM_REGS * DATA_STRB);

   logic ro_hit;
   logic priv_err;
   logic unused_prot;

   assign idx         = 8'(paddr >> LSB);
   assign hit         = (paddr < LIMIT) && ((paddr & ALIGN_MASK) == '0);
   assign priv_err    = PRIV_ONLY && !prot[PROT_PRIV_BIT];
   assign unused_prot = ^prot[2:1];

   // Look up whether the addressed register is hardware-owned
   always_comb begin
      ro_hit = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (idx == 8'(i)) begin
            ro_hit = RO_MASK[i];
         end
      end
   end

   assign err = !hit || (pwrite && ro_hit) || priv_err;
endmodule

// File: rtl/apb_regfile_slave.sv
// rtl/apb_regfile_slave.sv - APB slave with a bank of byte-writable registers, wait states and error response
module apb_regfile_slave
   import apb_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    DATA_STRB   = DATA_WIDTH / 8,
   parameter int                    NUM_REGS    = 16,
   parameter int                    WAIT_STATES = 0,
   parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
   parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0,
   parameter bit                    PRIV_ONLY   = 1'b0
) (
   input  logic                           clk,
   input  logic                           nrst,
   apb_regfile_slave_if.slave             bus,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_d,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);
   apb_state_e            state_q, state_d;
   logic [3:0]            wcnt_q, wcnt_d;
   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

   logic [7:0]            idx;
   logic                  hit;
   logic                  err;
   logic                  pready;
   logic [DATA_WIDTH-1:0] rd_word;

   apb_addr_decode #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_STRB  (DATA_STRB),
      .NUM_REGS   (NUM_REGS),
      .RO_MASK    (RO_MASK),
      .PRIV_ONLY  (PRIV_ONLY)
   ) u_decode (
      .paddr  (bus.paddr),
      .pwrite (bus.pwrite),
      .prot   (bus.prot),
      .idx    (idx),
      .hit    (hit),
      .err    (err)
   );

   assign pready     = (state_q == ACCESS) && bus.penable && (wcnt_q == 4'(WAIT_STATES));
   assign bus.pready = pready;
   assign bus.slverr = pready && err;
   assign bus.prdata = (pready && !bus.pwrite && !err) ? rd_word : '0;

   // Expose every register, with hardware-owned slots passed straight through
   always_comb begin
      reg_q = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         reg_q[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? ro_d[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
      end
   end

   // Select the addressed register's visible value for reads
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (idx == 8'(i)) begin
            rd_word = reg_q[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Next-state, wait counting and register update on an error-free write completion
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      regs_d  = regs_q;
      case (state_q)
         IDLE: begin
            if (bus.psel) begin
               state_d = SETUP;
            end
         end
         SETUP: begin
            state_d = ACCESS;
            wcnt_d  = '0;
         end
         ACCESS: begin
            if (!bus.psel) begin
               state_d = IDLE;
            end else if (pready) begin
               state_d = IDLE;
               if (bus.pwrite && !err) begin
                  for (int i = 0; i < NUM_REGS; i++) begin
                     if (idx == 8'(i)) begin
                        regs_d[i] = DATA_WIDTH'(byte_merge(MERGE_WIDTH'(regs_q[i]),
                                                           MERGE_WIDTH'(bus.pwdata),
                                                           MERGE_STRB'(bus.pstrb)));
                     end
                  end
               end
            end else if (wcnt_q < 4'(WAIT_STATES)) begin
               wcnt_d = wcnt_q + 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, wait counter and register bank; reset aborts any transfer in flight
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= IDLE;
         wcnt_q  <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= RESET_VAL;
         end
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         regs_q  <= regs_d;
      end
   end
endmodule

// File: doc/apb_regfile_slave.md
# apb_regfile_slave

Parametrised APB slave with a bank of `NUM_REGS` word-wide registers, byte-strobe writes, programmable wait states, and error signalling. It is the next generation of the team's single-register APB slave. It sits on the APB peripheral bus and exposes every register as a flat output bus for fabric logic. Designated read-only registers are sourced from a hardware input bus.

## Interface
- `ADDR_WIDTH`, 32, width of `paddr`.
- `DATA_WIDTH`, 32, data width; a multiple of 8.
- `DATA_STRB`, `DATA_WIDTH/8`, number of byte lanes.
- `NUM_REGS`, 16, number of registers; range 1..256.
- `WAIT_STATES`, 0, extra ACCESS cycles inserted before `pready`; range 0..15.
- `RO_MASK`, `'0`, `NUM_REGS` bits; bit i = 1 makes register i read-only.
- `RESET_VAL`, `'0`, reset value of every read/write register.
- `PRIV_ONLY`, 0, when 1, any access with `prot[0]`=0 is an error.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `nrst`  in  1  reset, asynchronous and active-low.
- `paddr`  in  `ADDR_WIDTH`  byte address.
- `prot`  in  3  protection type; only bit 0 (privileged) is used.
- `pwrite`  in  1  1 = write, 0 = read.
- `psel`  in  1  slave select.
- `penable`  in  1  access phase.
- `pwdata`  in  `DATA_WIDTH`  write data.
- `pstrb`  in  `DATA_STRB`  write byte enables.
- `pready`  out  1  transfer completes this cycle.
- `slverr`  out  1  transfer error; valid only when `pready`=1.
- `prdata`  out  `DATA_WIDTH`  read data; valid only on read completion.
- `ro_d`  in  `NUM_REGS*DATA_WIDTH`  read values for RO registers (slice i).
- `reg_q`  out  `NUM_REGS*DATA_WIDTH`  current register contents (slice i).

## Operation
- Register i lives at byte address i*`DATA_STRB`.
- FSM has three states:
  - IDLE -> SETUP when `psel`=1.
  - SETUP -> ACCESS unconditionally. If `psel`&`penable` arrive together in IDLE, that cycle is still taken as SETUP.
  - ACCESS -> IDLE on completion, or early if `psel` drops; an early exit causes no register update.
- Wait counter `wcnt` (4 bits):
  - Clears on entry to ACCESS.
  - Increments each ACCESS cycle while `wcnt` < `WAIT_STATES`.
  - `pready` = (state==ACCESS) & `penable` & (`wcnt`==`WAIT_STATES`).
- Completion cycle is `pready`=1. The error condition is the OR of:
  - address ≥ `NUM_REGS`*`DATA_STRB` (out of range),
  - low address bits misaligned (`paddr` mod `DATA_STRB` ≠ 0),
  - write to a register whose `RO_MASK` bit is 1,
  - `PRIV_ONLY`=1 and `prot[0]`=0.
- Write completion without error: for each lane b with `pstrb[b]`=1, byte b of the register takes `pwdata` byte b. Other bytes are kept. `pstrb`=0 is a legal no-op with no error.
- Write completion with error: no register changes.
- Read completion: `prdata` = `ro_d` slice (RO register) or stored value (RW register). On error `prdata` = 0.
- `reg_q` slice i = stored value for RW registers and `ro_d` slice i for RO registers.

## Timing
- Reset values: `pready`=0, `slverr`=0, `prdata`=0, FSM=IDLE, `wcnt`=0, every RW register = `RESET_VAL`.
- `pready` and `slverr` are combinational from state, `wcnt`, `penable` and address decode.
- `prdata` is combinational and is driven to 0 outside a read completion.
- Minimum transfer is 2 cycles (SETUP + ACCESS); latency is 2 + `WAIT_STATES` cycles.
- A written value is visible on `reg_q` and to a read from the first cycle after the completion edge.
- Back-to-back transfers: after completion the FSM returns to IDLE, so the next SETUP is the cycle after the IDLE cycle.
- `nrst` asserted mid-transfer aborts it immediately: no partial write, outputs go to their reset values.
- `ro_d` changes are reflected combinationally on reads and on `reg_q`.

## Structure
- Package `apb_pkg`:
  - FSM state enum `apb_state_e` {IDLE, SETUP, ACCESS},
  - `PROT_PRIV_BIT` = 0,
  - function `byte_merge(old, wdata, strb)`.
- One sub-module, `apb_addr_decode`: takes `paddr`/`pwrite`/`prot` and returns `idx`, `hit`, `err`.

## Test plan
- Reset, then write 0x1004 to address 0x8 with `pstrb`=4'hF, then read 0x8 -> `prdata`=0x1004, `slverr`=0, `reg_q` slice 2 = 0x1004.
- Write 0xAABBCCDD to 0x0, then 0x11223344 with `pstrb`=4'b0101, then read -> 0xAA22CC44.
- Access to address 0x2 (misaligned), and separately 0x40 with `NUM_REGS`=16 -> `slverr`=1 with `pready`; no register changes; `prdata`=0.
- `WAIT_STATES`=3: `pready` rises exactly 3 cycles after ACCESS entry; total transfer is 5 cycles.
- `RO_MASK` bit 1 set and `ro_d` slice 1 = 0xDEAD -> read 0x4 returns 0xDEAD; write to 0x4 -> `slverr`=1 and the value stays 0xDEAD.
- `PRIV_ONLY`=1 with `prot`=0 -> `slverr`=1. Separately, assert `nrst` during a wait state -> all registers = `RESET_VAL` and `pready`=0.
